// File: rtl/wb_map_pkg.sv
// Memory map and controller state type shared by the Wishbone bus controller and its decoder.
// Each slave owns a 256 MiB region selected by ADR[31:28].
package wb_map_pkg;

  localparam int MAX_SLAVES = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    ERR_RSP = 2'd2
  } wb_ctrl_state_t;

  localparam logic [31:0] SLAVE_BASE [MAX_SLAVES] = '{
    32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000,
    32'h4000_0000, 32'h5000_0000, 32'h6000_0000, 32'h7000_0000,
    32'h8000_0000, 32'h9000_0000, 32'hA000_0000, 32'hB000_0000,
    32'hC000_0000, 32'hD000_0000, 32'hE000_0000, 32'hF000_0000
  };

  localparam logic [31:0] SLAVE_MASK [MAX_SLAVES] = '{default: 32'hF000_0000};

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: reports whether ADR falls in any of the first N_SLAVES
// regions and which one, with the lowest index winning when regions overlap.
module wb_addr_decode
  import wb_map_pkg::*;
#(
  parameter int N_SLAVES = 6
) (
  input  logic [31:0] adr_i,
  output logic        hit_o,
  output logic [3:0]  idx_o
);

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    hit_o = 1'b0;
    idx_o = 4'd0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((adr_i & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
        hit_o = 1'b1;
        idx_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/wb_bus_ctrl.sv
// Wishbone bus controller in front of a 6-way slave mux: registers the slave select, passes
// the cycle through, and answers unmapped or timed-out cycles with a one-cycle ERR.
module wb_bus_ctrl
  import wb_map_pkg::*;
#(
  parameter  int N_SLAVES       = 6,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int CNT_W          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic        clk,
  input  logic        rst,
  // master side (core data master drives the request)
  input  logic        master_cyc_i,
  input  logic        master_stb_i,
  input  logic [31:0] master_adr_i,
  input  logic        master_we_i,
  input  logic [31:0] master_dat_i,
  output logic        master_ack_o,
  output logic        master_err_o,
  output logic        master_rty_o,
  output logic [31:0] master_dat_o,
  // mux side (muxed_out port of the slave mux)
  output logic        to_mux_cyc_o,
  output logic        to_mux_stb_o,
  output logic [31:0] to_mux_adr_o,
  output logic        to_mux_we_o,
  output logic [31:0] to_mux_dat_o,
  input  logic        to_mux_ack_i,
  input  logic        to_mux_err_i,
  input  logic        to_mux_rty_i,
  input  logic [31:0] to_mux_dat_i,
  // select and error capture
  output logic [3:0]  sel,
  output logic        err_valid,
  output logic        err_is_to,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  wb_ctrl_state_t     state_q;
  logic [3:0]         sel_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_valid_q;
  logic               err_is_to_q;
  logic [31:0]        err_addr_q;

  logic               hit;
  logic [3:0]         hit_idx;
  logic               req;
  logic               slv_rsp;
  logic               cnt_last;

  wb_addr_decode #(
    .N_SLAVES (N_SLAVES)
  ) u_decode (
    .adr_i (master_adr_i),
    .hit_o (hit),
    .idx_o (hit_idx)
  );

  assign req      = master_cyc_i & master_stb_i;
  assign slv_rsp  = to_mux_ack_i | to_mux_err_i | to_mux_rty_i;
  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sel_q       <= 4'd0;
      cnt_q       <= '0;
      err_valid_q <= 1'b0;
      err_is_to_q <= 1'b0;
      err_addr_q  <= 32'd0;
    end else begin
      // A new error captured below in the same cycle overrides this clear.
      if (err_clr) err_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              sel_q   <= hit_idx;
              cnt_q   <= '0;
              state_q <= ACTIVE;
            end else begin
              err_valid_q <= 1'b1;
              err_is_to_q <= 1'b0;
              err_addr_q  <= master_adr_i;
              state_q     <= ERR_RSP;
            end
          end
        end
        ACTIVE: begin
          if (!master_cyc_i || slv_rsp) begin
            state_q <= IDLE;
          end else if (cnt_last) begin
            err_valid_q <= 1'b1;
            err_is_to_q <= 1'b1;
            err_addr_q  <= master_adr_i;
            state_q     <= ERR_RSP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ERR_RSP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The slave sees the master only while ACTIVE; responses return with no added latency.
  always_comb begin
    to_mux_cyc_o = 1'b0;
    to_mux_stb_o = 1'b0;
    to_mux_adr_o = 32'd0;
    to_mux_we_o  = 1'b0;
    to_mux_dat_o = 32'd0;
    master_ack_o = 1'b0;
    master_err_o = 1'b0;
    master_rty_o = 1'b0;
    master_dat_o = 32'd0;
    case (state_q)
      ACTIVE: begin
        to_mux_cyc_o = master_cyc_i;
        to_mux_stb_o = master_cyc_i & master_stb_i;
        to_mux_adr_o = master_adr_i;
        to_mux_we_o  = master_we_i;
        to_mux_dat_o = master_dat_i;
        master_ack_o = master_cyc_i & to_mux_ack_i;
        master_err_o = master_cyc_i & to_mux_err_i;
        master_rty_o = master_cyc_i & to_mux_rty_i;
        master_dat_o = to_mux_dat_i;
      end
      ERR_RSP: master_err_o = 1'b1;
      default: ;
    endcase
  end

  assign sel       = sel_q;
  assign err_valid = err_valid_q;
  assign err_is_to = err_is_to_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_wb_bus_ctrl.sv
// Self-checking bench for wb_bus_ctrl: directed scenarios plus random transactions checked
// against a transaction-level model of the memory map, timeout and error capture.
module tb_wb_bus_ctrl;

  localparam int TO = 16;
  localparam int NS = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        mcyc, mstb, mwe;
  logic [31:0] madr, mwdat;
  logic        master_ack_o, master_err_o, master_rty_o;
  logic [31:0] master_dat_o;
  logic        to_mux_cyc_o, to_mux_stb_o, to_mux_we_o;
  logic [31:0] to_mux_adr_o, to_mux_dat_o;
  logic        sack, serr, srty;
  logic [31:0] sdat;
  logic [3:0]  sel;
  logic        err_valid, err_is_to, err_clr;
  logic [31:0] err_addr;

  always #5 clk = ~clk;

  wb_bus_ctrl #(.N_SLAVES(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .master_cyc_i(mcyc), .master_stb_i(mstb), .master_adr_i(madr), .master_we_i(mwe),
    .master_dat_i(mwdat), .master_ack_o(master_ack_o), .master_err_o(master_err_o),
    .master_rty_o(master_rty_o), .master_dat_o(master_dat_o),
    .to_mux_cyc_o(to_mux_cyc_o), .to_mux_stb_o(to_mux_stb_o), .to_mux_adr_o(to_mux_adr_o),
    .to_mux_we_o(to_mux_we_o), .to_mux_dat_o(to_mux_dat_o), .to_mux_ack_i(sack),
    .to_mux_err_i(serr), .to_mux_rty_i(srty), .to_mux_dat_i(sdat),
    .sel(sel), .err_valid(err_valid), .err_is_to(err_is_to), .err_addr(err_addr),
    .err_clr(err_clr)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference view of the sticky error registers.
  bit          exp_ev = 0, exp_to = 0;
  logic [31:0] exp_ea = 32'd0;

  // Per-transaction observations.
  int          m_stb, m_first_stb, m_rsp_kind, m_rsp_cyc, m_rsp_n;
  int          m_tail_bad, m_pass_bad, m_sel_min, m_sel_max, m_abort_bad;
  logic [31:0] m_rdat;
  bit          m_hung;

  function automatic bit ref_hit(input logic [31:0] a);
    return int'(a[31:28]) < NS;
  endfunction

  // kind: 1=ACK 2=ERR 3=RTY; ack_on = STB cycle (1-based) on which the slave responds, 0 = never.
  task automatic run_txn(input logic [31:0] adr, input bit we, input logic [31:0] wdat,
                         input int ack_on, input int kind, input logic [31:0] rdat,
                         input int abort_on, input bit tail);
    bit done = 0;
    int stb_n = 0;
    m_first_stb = -1; m_rsp_kind = 0; m_rsp_cyc = -1; m_rsp_n = 0; m_tail_bad = 0;
    m_pass_bad = 0; m_sel_min = 99; m_sel_max = -1; m_abort_bad = 0; m_rdat = '0; m_hung = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (abort_on != 0 && c == abort_on) begin
        mcyc = 0; mstb = 0;
      end else begin
        mcyc = 1; mstb = 1; madr = adr; mwe = we; mwdat = wdat;
      end
      sack = 0; serr = 0; srty = 0; sdat = '0;
      @(negedge clk);
      if (to_mux_cyc_o && to_mux_stb_o) begin
        stb_n++;
        if (m_first_stb < 0) m_first_stb = c;
        if (int'(sel) < m_sel_min) m_sel_min = int'(sel);
        if (int'(sel) > m_sel_max) m_sel_max = int'(sel);
        if (to_mux_adr_o !== adr || to_mux_we_o !== we || to_mux_dat_o !== wdat) m_pass_bad++;
        if (stb_n == ack_on) begin
          sack = (kind == 1); serr = (kind == 2); srty = (kind == 3); sdat = rdat;
        end
      end
      #1;
      if (master_ack_o || master_err_o || master_rty_o) begin
        m_rsp_n++;
        m_rsp_kind = master_ack_o ? 1 : (master_err_o ? 2 : 3);
        m_rsp_cyc = c;
        m_rdat = master_dat_o;
        done = 1;
      end
      if (abort_on != 0 && c == abort_on) begin
        if (to_mux_cyc_o !== 1'b0) m_abort_bad++;
        done = 1;
      end
      @(posedge clk); #1;
    end
    m_stb = stb_n;
    m_hung = !done;
    mcyc = 0; mstb = 0; sack = 0; serr = 0; srty = 0; sdat = '0;
    if (tail) begin
      @(negedge clk);
      if (to_mux_cyc_o || to_mux_stb_o || master_ack_o || master_err_o || master_rty_o)
        m_tail_bad++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 0; mcyc = 1; mstb = 1; madr = 32'hF000_0000; mwe = 1; mwdat = 32'hDEAD_BEEF;
    sack = 1; serr = 1; srty = 1; sdat = 32'h1234_5678; err_clr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (sel !== 4'd0) begin miscompares++; $display("FAIL reset_sel got %0d want 0", sel); end
    vectors++; if ({err_valid, err_is_to} !== 2'b00) begin miscompares++; $display("FAIL reset_err_flags got %b%b want 00", err_valid, err_is_to); end
    vectors++; if (err_addr !== 32'd0) begin miscompares++; $display("FAIL reset_err_addr got %h want 0", err_addr); end
    vectors++; if ({master_ack_o, master_err_o, master_rty_o} !== 3'b000 || master_dat_o !== 32'd0) begin miscompares++; $display("FAIL reset_master_rsp got %b%b%b dat %h want 000/0", master_ack_o, master_err_o, master_rty_o, master_dat_o); end
    vectors++; if ({to_mux_cyc_o, to_mux_stb_o, to_mux_we_o} !== 3'b000 || to_mux_adr_o !== 32'd0 || to_mux_dat_o !== 32'd0) begin miscompares++; $display("FAIL reset_to_mux got %b%b%b adr %h dat %h want 0", to_mux_cyc_o, to_mux_stb_o, to_mux_we_o, to_mux_adr_o, to_mux_dat_o); end
    @(posedge clk); #1;
    mcyc = 0; mstb = 0; mwe = 0; sack = 0; serr = 0; srty = 0; sdat = '0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_slave2();
    logic [31:0] rd = $urandom;
    run_txn(32'h2000_0010, 0, 32'd0, 4, 1, rd, 0, 1);
    vectors++; if (m_first_stb !== 1) begin miscompares++; $display("FAIL rd2_stb_latency got %0d want 1", m_first_stb); end
    vectors++; if (m_sel_min !== 2 || m_sel_max !== 2) begin miscompares++; $display("FAIL rd2_sel got %0d..%0d want 2", m_sel_min, m_sel_max); end
    vectors++; if (m_stb !== 4) begin miscompares++; $display("FAIL rd2_stb_cycles got %0d want 4", m_stb); end
    vectors++; if (m_rsp_kind !== 1 || m_rsp_cyc !== 4) begin miscompares++; $display("FAIL rd2_ack got kind %0d cyc %0d want 1/4", m_rsp_kind, m_rsp_cyc); end
    vectors++; if (m_rdat !== rd) begin miscompares++; $display("FAIL rd2_data got %h want %h", m_rdat, rd); end
    vectors++; if (m_tail_bad !== 0 || m_pass_bad !== 0) begin miscompares++; $display("FAIL rd2_idle_after got tail %0d pass %0d want 0/0", m_tail_bad, m_pass_bad); end
    vectors++; if (sel !== 4'd2 || err_valid !== 1'b0) begin miscompares++; $display("FAIL rd2_hold got sel %0d ev %b want 2/0", sel, err_valid); end
  endtask

  task automatic test_unmapped();
    run_txn(32'hF000_0000, 0, 32'd0, 1, 1, 32'd0, 0, 1);
    exp_ev = 1; exp_to = 0; exp_ea = 32'hF000_0000;
    vectors++; if (m_stb !== 0) begin miscompares++; $display("FAIL unmap_stb got %0d want 0", m_stb); end
    vectors++; if (m_rsp_kind !== 2 || m_rsp_cyc !== 1 || m_rsp_n !== 1) begin miscompares++; $display("FAIL unmap_err got kind %0d cyc %0d n %0d want 2/1/1", m_rsp_kind, m_rsp_cyc, m_rsp_n); end
    vectors++; if (m_tail_bad !== 0) begin miscompares++; $display("FAIL unmap_err_width got %0d extra cycles want 0", m_tail_bad); end
    vectors++; if ({err_valid, err_is_to} !== {exp_ev, exp_to} || err_addr !== exp_ea) begin miscompares++; $display("FAIL unmap_capture got %b%b %h want %b%b %h", err_valid, err_is_to, err_addr, exp_ev, exp_to, exp_ea); end
    vectors++; if (sel !== 4'd2) begin miscompares++; $display("FAIL unmap_sel_hold got %0d want 2", sel); end
  endtask

  task automatic test_abort();
    run_txn(32'h1000_0000, 0, 32'd0, 0, 1, 32'd0, 2, 1);
    vectors++; if (m_rsp_n !== 0) begin miscompares++; $display("FAIL abort_rsp got %0d responses want 0", m_rsp_n); end
    vectors++; if (m_abort_bad !== 0 || m_stb !== 1) begin miscompares++; $display("FAIL abort_cyc got bad %0d stb %0d want 0/1", m_abort_bad, m_stb); end
    vectors++; if (m_tail_bad !== 0) begin miscompares++; $display("FAIL abort_idle got %0d want 0", m_tail_bad); end
    vectors++; if ({err_valid, err_is_to} !== {exp_ev, exp_to} || err_addr !== exp_ea) begin miscompares++; $display("FAIL abort_err_regs got %b%b %h want %b%b %h", err_valid, err_is_to, err_addr, exp_ev, exp_to, exp_ea); end
  endtask

  task automatic test_timeout();
    run_txn(32'h3000_0100, 1, 32'hCAFE_0001, 0, 1, 32'd0, 0, 0);
    exp_ev = 1; exp_to = 1; exp_ea = 32'h3000_0100;
    vectors++; if (m_stb !== TO || m_first_stb !== 1) begin miscompares++; $display("FAIL to_stb got %0d from %0d want %0d from 1", m_stb, m_first_stb, TO); end
    vectors++; if (m_rsp_kind !== 2 || m_rsp_cyc !== TO + 1) begin miscompares++; $display("FAIL to_err got kind %0d cyc %0d want 2/%0d", m_rsp_kind, m_rsp_cyc, TO + 1); end
    vectors++; if ({err_valid, err_is_to} !== 2'b11 || err_addr !== exp_ea) begin miscompares++; $display("FAIL to_capture got %b%b %h want 11 %h", err_valid, err_is_to, err_addr, exp_ea); end
    sack = 1; sdat = 32'h5555_AAAA;
    @(negedge clk);
    vectors++; if ({master_ack_o, master_err_o, to_mux_cyc_o} !== 3'b000) begin miscompares++; $display("FAIL to_late_ack got ack %b err %b cyc %b want 000", master_ack_o, master_err_o, to_mux_cyc_o); end
    @(posedge clk); #1;
    sack = 0; sdat = '0; err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0; exp_ev = 0;
    @(negedge clk);
    vectors++; if (err_valid !== 1'b0) begin miscompares++; $display("FAIL to_clear got %b want 0", err_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_clr_collision();
    mcyc = 1; mstb = 1; madr = 32'hE123_4560; mwe = 0; mwdat = 32'd0; err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0; exp_ev = 1; exp_to = 0; exp_ea = 32'hE123_4560;
    @(negedge clk);
    vectors++; if ({err_valid, err_is_to} !== 2'b10 || err_addr !== exp_ea) begin miscompares++; $display("FAIL clr_coll got %b%b %h want 10 %h", err_valid, err_is_to, err_addr, exp_ea); end
    vectors++; if (master_err_o !== 1'b1) begin miscompares++; $display("FAIL clr_coll_rsp got %b want 1", master_err_o); end
    @(posedge clk); #1;
    mcyc = 0; mstb = 0;
    @(negedge clk);
    vectors++; if (master_err_o !== 1'b0) begin miscompares++; $display("FAIL clr_coll_width got %b want 0", master_err_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    run_txn(32'h0000_0040, 1, 32'h0A0A_0A0A, 2, 1, 32'd0, 0, 0);
    vectors++; if (m_sel_min !== 0 || m_sel_max !== 0 || m_rsp_kind !== 1 || m_rsp_cyc !== 2) begin miscompares++; $display("FAIL b2b_first got sel %0d..%0d kind %0d cyc %0d want 0..0 1 2", m_sel_min, m_sel_max, m_rsp_kind, m_rsp_cyc); end
    run_txn(32'h5000_0080, 1, 32'h5B5B_5B5B, 1, 1, 32'd0, 0, 1);
    vectors++; if (m_first_stb !== 1) begin miscompares++; $display("FAIL b2b_gap got first stb %0d want 1", m_first_stb); end
    vectors++; if (m_sel_min !== 5 || m_sel_max !== 5 || m_pass_bad !== 0) begin miscompares++; $display("FAIL b2b_second got sel %0d..%0d pass %0d want 5..5 0", m_sel_min, m_sel_max, m_pass_bad); end
    vectors++; if (m_rsp_kind !== 1 || m_rsp_cyc !== 1 || m_tail_bad !== 0) begin miscompares++; $display("FAIL b2b_ack got kind %0d cyc %0d tail %0d want 1 1 0", m_rsp_kind, m_rsp_cyc, m_tail_bad); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] rd = $urandom;
      bit we = 1'($urandom_range(0, 1));
      int ack_on = $urandom_range(0, TO + 2);
      int kind = $urandom_range(1, 5);
      int exp_stb, exp_kind, exp_cyc;
      bit mapped;
      if (kind > 3) kind = 1;
      if ($urandom_range(0, 3) != 0) a[31:28] = 4'($urandom_range(0, NS - 1));
      mapped = ref_hit(a);
      run_txn(a, we, wd, ack_on, kind, rd, 0, 1);
      if (!mapped) begin
        exp_stb = 0; exp_kind = 2; exp_cyc = 1;
        exp_ev = 1; exp_to = 0; exp_ea = a;
      end else if (ack_on >= 1 && ack_on <= TO) begin
        exp_stb = ack_on; exp_kind = kind; exp_cyc = ack_on;
      end else begin
        exp_stb = TO; exp_kind = 2; exp_cyc = TO + 1;
        exp_ev = 1; exp_to = 1; exp_ea = a;
      end
      vectors++; if (m_hung || m_rsp_n !== 1) begin miscompares++; $display("FAIL rand%0d_done got hung %0d rsp %0d want 0/1", n, m_hung, m_rsp_n); end
      vectors++; if (m_stb !== exp_stb) begin miscompares++; $display("FAIL rand%0d_stb got %0d want %0d (adr %h)", n, m_stb, exp_stb, a); end
      vectors++; if (m_rsp_kind !== exp_kind || m_rsp_cyc !== exp_cyc) begin miscompares++; $display("FAIL rand%0d_rsp got kind %0d cyc %0d want %0d/%0d", n, m_rsp_kind, m_rsp_cyc, exp_kind, exp_cyc); end
      vectors++; if (m_tail_bad !== 0 || m_pass_bad !== 0) begin miscompares++; $display("FAIL rand%0d_bus got tail %0d pass %0d want 0/0", n, m_tail_bad, m_pass_bad); end
      if (mapped) begin
        vectors++; if (m_sel_min !== int'(a[31:28]) || m_sel_max !== int'(a[31:28])) begin miscompares++; $display("FAIL rand%0d_sel got %0d..%0d want %0d", n, m_sel_min, m_sel_max, a[31:28]); end
      end
      if (exp_kind == 1) begin
        vectors++; if (m_rdat !== rd) begin miscompares++; $display("FAIL rand%0d_rdat got %h want %h", n, m_rdat, rd); end
      end
      vectors++; if ({err_valid, err_is_to} !== {exp_ev, exp_to} || err_addr !== exp_ea) begin miscompares++; $display("FAIL rand%0d_err got %b%b %h want %b%b %h", n, err_valid, err_is_to, err_addr, exp_ev, exp_to, exp_ea); end
    end
  endtask

  task automatic test_reset_mid();
    run_txn(32'hB000_0004, 0, 32'd0, 1, 1, 32'd0, 0, 1);
    mcyc = 1; mstb = 1; madr = 32'h4000_0000; mwe = 1; mwdat = 32'h7777_0000;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (to_mux_stb_o !== 1'b1 || sel !== 4'd4 || err_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_active got stb %b sel %0d ev %b want 1/4/1", to_mux_stb_o, sel, err_valid); end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (sel !== 4'd0 || {to_mux_cyc_o, to_mux_stb_o, to_mux_we_o} !== 3'b000 || to_mux_adr_o !== 32'd0) begin miscompares++; $display("FAIL rstmid_bus got sel %0d cyc/stb/we %b%b%b adr %h want 0", sel, to_mux_cyc_o, to_mux_stb_o, to_mux_we_o, to_mux_adr_o); end
    vectors++; if ({master_ack_o, master_err_o, master_rty_o} !== 3'b000) begin miscompares++; $display("FAIL rstmid_rsp got %b%b%b want 000", master_ack_o, master_err_o, master_rty_o); end
    vectors++; if ({err_valid, err_is_to} !== 2'b00 || err_addr !== 32'd0) begin miscompares++; $display("FAIL rstmid_err got %b%b %h want 00 0", err_valid, err_is_to, err_addr); end
    @(posedge clk); #1;
    mcyc = 0; mstb = 0; mwe = 0;
    @(posedge clk); #1;
    rst = 1;
    exp_ev = 0; exp_to = 0; exp_ea = 32'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 0; mcyc = 0; mstb = 0; madr = '0; mwe = 0; mwdat = '0;
    sack = 0; serr = 0; srty = 0; sdat = '0; err_clr = 0;
    test_reset();
    test_read_slave2();
    test_unmapped();
    test_abort();
    test_timeout();
    test_clr_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
